// File: rtl/memc_deskew_if.sv
// Host-side bus of the deskew buffer: skewed capture lanes in, registered row reads out.
// The master side drives the strobes and skewed lanes. The slave side is the buffer itself.
interface memc_deskew_if #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
);
    logic                                 en;
    logic                                 clr;
    logic signed [DIM-1:0][BITS_C-1:0]    Cin;
    logic                                 RdEn;
    logic        [$clog2(DIM)-1:0]        Crow;
    logic signed [DIM-1:0][BITS_C-1:0]    Cout;
    logic                                 Cvalid;
    logic                                 full;
    logic                                 busy;

    modport master (
        output en, clr, Cin, RdEn, Crow,
        input  Cout, Cvalid, full, busy
    );

    modport slave (
        input  en, clr, Cin, RdEn, Crow,
        output Cout, Cvalid, full, busy
    );
endinterface

// File: rtl/memc_deskew.sv
// Deskew buffer: undoes the diagonal skew of the systolic array output into a DIM x DIM
// matrix, then serves nondestructive row reads with a one-cycle registered latency.
module memc_deskew_lane #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8,
    parameter int LANE   = 0,
    parameter int KW     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_cap,
    input  logic [KW-1:0]                i_k,
    input  logic [BITS_C-1:0]            i_d,
    output logic [DIM-1:0][BITS_C-1:0]   o_row
);
    localparam int CW = $clog2(DIM);

    logic [DIM-1:0][BITS_C-1:0] r_row;
    logic [KW-1:0]              w_col;
    logic                       w_win;

    // Lane LANE carries column k-LANE at step k; anything outside the diagonal is junk.
    assign w_col = i_k - KW'(LANE);
    assign w_win = (i_k >= KW'(LANE)) && (w_col < KW'(DIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
        end else if (i_clr) begin
            r_row <= '0;
        end else if (i_cap && w_win) begin
            r_row[w_col[CW-1:0]] <= i_d;
        end
    end

    assign o_row = r_row;
endmodule

module memc_deskew #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    memc_deskew_if.slave   bus
);
    localparam int KW = $clog2(2 * DIM);
    localparam logic [KW-1:0] K_LAST = KW'(2 * DIM - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAP,
        S_FULL
    } state_t;

    state_t                              r_state;
    logic [KW-1:0]                       r_k;
    logic                                r_full;
    logic                                r_busy;
    logic                                r_cvalid;
    logic [DIM-1:0][BITS_C-1:0]          r_cout;
    logic [DIM-1:0][DIM-1:0][BITS_C-1:0] w_rows;
    logic                                w_cap;
    logic                                w_rd;

    // A step is consumed only while the matrix is still filling; clr always wins.
    assign w_cap = bus.en && !bus.clr && (r_state != S_FULL);
    assign w_rd  = bus.RdEn && !bus.clr && (r_state == S_FULL);

    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_lane
            memc_deskew_lane #(
                .BITS_C (BITS_C),
                .DIM    (DIM),
                .LANE   (gi),
                .KW     (KW)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_clr  (bus.clr),
                .i_cap  (w_cap),
                .i_k    (r_k),
                .i_d    (bus.Cin[gi]),
                .o_row  (w_rows[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_full   <= 1'b0;
            r_busy   <= 1'b0;
            r_cvalid <= 1'b0;
            r_cout   <= '0;
        end else if (bus.clr) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_full   <= 1'b0;
            r_busy   <= 1'b0;
            r_cvalid <= 1'b0;
            r_cout   <= '0;
        end else begin
            r_cvalid <= w_rd;
            if (w_rd) begin
                r_cout <= w_rows[bus.Crow];
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        r_state <= S_CAP;
                        r_k     <= r_k + 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_CAP: begin
                    if (bus.en) begin
                        // Hold k at the last step so the counter never wraps.
                        if (r_k == K_LAST) begin
                            r_state <= S_FULL;
                            r_full  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    r_state <= S_FULL;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Cout   = r_cout;
    assign bus.Cvalid = r_cvalid;
    assign bus.full   = r_full;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_memc_deskew.sv
// Directed bench for memc_deskew: skewed capture passes, stalls, clr aborts, FULL lock,
// with a scoreboard queue of expected rows popped by an independent monitor.
module tb_memc_deskew;
    localparam int BITS_C = 16;
    localparam int DIM    = 8;

    typedef logic signed [BITS_C-1:0]           elem_t;
    typedef elem_t                              mat_t [DIM][DIM];
    typedef logic        [DIM-1:0][BITS_C-1:0]  row_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    row_t exp_q [$];

    memc_deskew_if #(.BITS_C(BITS_C), .DIM(DIM)) dif ();

    memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every Cvalid must match the oldest outstanding expected row.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dif.Cvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cvalid: got Cout %0h expected no read", dif.Cout);
            end else begin
                row_t e;
                e = exp_q.pop_front();
                if (dif.Cout !== e) begin
                    errors++;
                    $display("FAIL row_data: got %0h expected %0h", dif.Cout, e);
                end
            end
        end
    end

    function automatic row_t row_of(input mat_t m, input int r);
        row_t v;
        for (int c = 0; c < DIM; c++) v[c] = m[r][c];
        return v;
    endfunction

    task automatic drive_step(input mat_t m, input int k);
        for (int i = 0; i < DIM; i++) begin
            if (k - i >= 0 && k - i < DIM) dif.Cin[i] = m[i][k-i];
            else                           dif.Cin[i] = 16'sh7FFF;
        end
    endtask

    task automatic capture(input mat_t m, input bit stall, input int abort_at);
        for (int k = 0; k < 2*DIM-1; k++) begin
            @(negedge clk);
            if (k == 0)       chk("busy_idle", 128'(dif.busy), 128'd0);
            if (k == 1)       chk("busy_capture", 128'(dif.busy), 128'd1);
            if (k == 2*DIM-2) chk("full_early", 128'(dif.full), 128'd0);
            if (k == abort_at) begin
                dif.clr = 1'b1;
                dif.en  = 1'b1;
                drive_step(m, k);
                @(negedge clk);
                dif.clr = 1'b0;
                dif.en  = 1'b0;
                chk("abort_busy", 128'(dif.busy), 128'd0);
                chk("abort_full", 128'(dif.full), 128'd0);
                return;
            end
            dif.en = 1'b1;
            drive_step(m, k);
            if (stall && (k == 5 || k == 11)) begin
                for (int j = 0; j < ((k == 5) ? 3 : 1); j++) begin
                    @(negedge clk);
                    dif.en = 1'b0;
                    chk("busy_stall", 128'(dif.busy), 128'd1);
                end
            end
        end
        @(negedge clk);
        dif.en = 1'b0;
        chk("full_set", 128'(dif.full), 128'd1);
        chk("busy_done", 128'(dif.busy), 128'd0);
    endtask

    task automatic read_all(input mat_t m);
        for (int r = 0; r < DIM; r++) begin
            @(negedge clk);
            dif.RdEn = 1'b1;
            dif.Crow = 3'(r);
            exp_q.push_back(row_of(m, r));
        end
        @(negedge clk);
        dif.RdEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        dif.clr = 1'b1;
        @(negedge clk);
        dif.clr = 1'b0;
        chk("clr_full", 128'(dif.full), 128'd0);
        chk("clr_cout", 128'(dif.Cout), 128'd0);
    endtask

    mat_t m2, m3, m4, m5;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        dif.en    = 1'b0;
        dif.clr   = 1'b0;
        dif.RdEn  = 1'b0;
        dif.Crow  = '0;
        dif.Cin   = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                m2[r][c] = elem_t'(r*16 + c);
                m3[r][c] = elem_t'($urandom);
                m4[r][c] = elem_t'((r*DIM + c)*37 - 1000);
                m5[r][c] = elem_t'(-(r + c));
            end
        m3[0][0] = 16'sh8000;
        m3[7][7] = 16'sh8000;
        m3[4][2] = 16'sh7FFE;

        // 1: asynchronous reset mid-cycle, then reads outside FULL are ignored
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_cout", 128'(dif.Cout), 128'd0);
        chk("rst_cvalid", 128'(dif.Cvalid), 128'd0);
        chk("rst_full", 128'(dif.full), 128'd0);
        chk("rst_busy", 128'(dif.busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            if (r > 0) chk("idle_read_cvalid", 128'(dif.Cvalid), 128'd0);
            dif.RdEn = 1'b1;
            dif.Crow = 3'(r);
        end
        @(negedge clk);
        dif.RdEn = 1'b0;
        chk("idle_read_cvalid", 128'(dif.Cvalid), 128'd0);
        chk("idle_read_cout", 128'(dif.Cout), 128'd0);

        // 2: plain capture of r*16+c
        capture(m2, 1'b0, -1);
        read_all(m2);
        do_clr();

        // 3: random signed values with 0x7FFF in every don't-care slot
        capture(m3, 1'b0, -1);
        read_all(m3);
        do_clr();

        // 4: stalls after steps 5 and 11
        capture(m4, 1'b1, -1);
        read_all(m4);
        do_clr();

        // 5: abort at step 7, then a fresh pass of -(r+c)
        capture(m3, 1'b0, 7);
        capture(m5, 1'b0, -1);
        read_all(m5);

        // 6: FULL ignores en, then clr beats RdEn
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            dif.en  = 1'b1;
            dif.Cin = {DIM{16'h5555}};
        end
        @(negedge clk);
        dif.en = 1'b0;
        chk("full_locked", 128'(dif.full), 128'd1);
        read_all(m5);
        dif.clr  = 1'b1;
        dif.RdEn = 1'b1;
        dif.Crow = 3'd3;
        @(negedge clk);
        dif.clr  = 1'b0;
        chk("prio_cvalid", 128'(dif.Cvalid), 128'd0);
        chk("prio_cout", 128'(dif.Cout), 128'd0);
        chk("prio_full", 128'(dif.full), 128'd0);
        @(negedge clk);
        dif.RdEn = 1'b0;
        chk("idle_after_clr_cvalid", 128'(dif.Cvalid), 128'd0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
